mfp_ahb_multibot_io: RTL and testbench
======================================

MFP_AHB_MULTIBOT_IO -- requirements
Module: mfp_ahb_multibot_io

Interface
REQ-001 Parameter NUM_BOTS, default 2, number of Rojobot channels; legal range 1..4.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on each update input; legal range 2..3.
REQ-003 HCLK  input  1  AHB clock; all state is on its rising edge.
REQ-004 HRESETn  input  1  asynchronous, active-low reset.
REQ-005 HADDR  input  8  AHB address, low 8 bits only.
REQ-006 HWDATA  input  32  AHB write data, valid in the data phase.
REQ-007 HWRITE, HSEL  input  1 each  AHB write strobe and slave select.
REQ-008 HTRANS  input  2  AHB transfer type; 2'b00 is IDLE.
REQ-009 H_BOT_INFO  input  NUM_BOTS*32  bot info; channel n is at [32n+31:32n].
REQ-010 H_BOT_UPDATE  input  NUM_BOTS  per-bot update strobe, asynchronous to HCLK; each high level lasts at least 2 HCLK periods.
REQ-011 H_BOT_CTRL  output  NUM_BOTS*8  bot control; channel n is at [8n+7:8n].
REQ-012 H_IRQ  output  1  registered interrupt request to the CPU.
REQ-013 HRDATA  output  32  registered AHB read data.

Function
REQ-014 Register map, with channel base B = 0x20*n:
  - B+0x00 INFO, RO: snapshot of the channel's bot info.
  - B+0x04 CTRL, RW: bits [7:0].
  - B+0x08 STATUS, RO: bit0 = pending, bits [15:8] = overrun count, all other bits 0.
  - B+0x0C ACK, WO, write-1-to-clear: bit0 clears pending, bit1 clears the overrun count.
REQ-015 Global registers:
  - 0x80 IRQ_EN, RW: bits [NUM_BOTS-1:0].
  - 0x84 IRQ_PEND, RO: bits [NUM_BOTS-1:0] = pending flags of all channels.
REQ-016 Write qualifier: HADDR, HWRITE, HSEL and HTRANS are registered at the end of the address phase. A write is performed at the end of the data phase only if the registered values give HSEL=1, HWRITE=1 and HTRANS!=IDLE.
REQ-017 Read: HRDATA is loaded at the end of the address phase when HSEL=1, HWRITE=0 and HTRANS!=IDLE. Data is therefore valid in the following (data-phase) cycle, with zero wait states.
REQ-018 Fixed-zero reads: unmapped addresses, channels n>=NUM_BOTS, ACK addresses, and unused register bits all read 0.
REQ-019 Ignored writes: writes to RO registers, unmapped addresses, or channels n>=NUM_BOTS have no effect.
REQ-020 Update detection, per channel:
  - H_BOT_UPDATE[n] passes through a SYNC_STAGES-flop synchronizer, then a rising-edge detector (one extra flop).
  - A detected edge is a one-HCLK pulse on the last synchronizer stage going 0->1.
REQ-021 On a detected edge, INFO[n] captures H_BOT_INFO[n] and pending[n] is set in the same cycle.
  - Latency: SYNC_STAGES+1 HCLK edges after H_BOT_UPDATE[n] rises.
REQ-022 Overrun: a detected edge while pending[n] is already 1 increments overrun[n], saturating at 255, and still refreshes INFO[n].
REQ-023 Simultaneous ACK bit0 write and detected edge on the same channel and cycle:
  - the set wins, so pending stays 1;
  - the overrun count does not increment.
REQ-024 Simultaneous ACK bit1 write and overrun increment: the clear wins, so the count becomes 0.
REQ-025 H_IRQ is registered to the OR over n of (pending[n] AND IRQ_EN[n]). It follows pending or IRQ_EN changes by one HCLK.
REQ-026 H_BOT_CTRL[n] is driven directly from CTRL[n].
REQ-027 Channels are fully independent; events on different channels in the same cycle are all processed.

Reset
REQ-028 While HRESETn=0, the following are 0 immediately and held at 0: HRDATA, H_BOT_CTRL, H_IRQ, all INFO, CTRL, pending and overrun registers, IRQ_EN, synchronizer and edge flops, and the registered AHB phase signals.
REQ-029 Reset asserted mid-transfer aborts that transfer; no write completes in the cycle of or after reset deassertion unless a new address phase occurs.
REQ-030 An H_BOT_UPDATE input that is already high at reset release produces one detected edge, SYNC_STAGES+1 cycles after release.

Verification
REQ-031 Write 0xA5 to 0x04, then 0x3C to 0x24 -> H_BOT_CTRL=0x3CA5; reading 0x04 returns 0x000000A5 in the next cycle.
REQ-032 H_BOT_INFO[0]=0x12345678, pulse H_BOT_UPDATE[0] (NUM_BOTS=2, SYNC_STAGES=2) -> at the 3rd edge INFO0=0x12345678 and STATUS0 bit0=1; with IRQ_EN=0x1, H_IRQ=1 one cycle later.
REQ-033 Three update pulses with no ACK -> STATUS0=0x00000201; write 0x3 to 0x0C -> STATUS0=0 and H_IRQ=0 one cycle later.
REQ-034 300 update pulses with no ACK -> overrun count holds at 0xFF; an ACK bit0 write coincident with a detected edge -> pending stays 1 and the count is unchanged.
REQ-035 Write and read at 0x60 and 0x88 with NUM_BOTS=2, and HTRANS=IDLE with HSEL=1 and HWRITE=1 -> no state changes, reads return 0.
REQ-036 Assert HRESETn=0 during a CTRL write data phase -> all outputs 0 immediately; CTRL remains 0 after release.

Source files
------------

// File: rtl/mfp_ahb_multibot_io_if.sv
// ---------------------------------------------------------------------------
// mfp_ahb_multibot_io_if
//   AHB-Lite slave bus bundle for the multi-Rojobot I/O block.
//
//   Signals:
//     HADDR  [7:0]  byte address (low 8 bits of the system address)
//     HWDATA [31:0] write data, valid in the data phase
//     HWRITE        1 = write, 0 = read
//     HSEL          slave select
//     HTRANS [1:0]  transfer type, 2'b00 = IDLE
//     HRDATA [31:0] registered read data
//
//   Handshake: this slave has zero wait states, so HREADY is implicitly 1.
//   An address phase is "valid" when HSEL=1 and HTRANS!=IDLE, and it is
//   always accepted on the rising HCLK edge that ends it. The matching data
//   phase is the next cycle: HWDATA must be valid in it for writes, and
//   HRDATA is valid in it for reads.
// ---------------------------------------------------------------------------
interface mfp_ahb_multibot_io_if;
  logic [7:0]  HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;

  modport master (
    output HADDR, HWDATA, HWRITE, HSEL, HTRANS,
    input  HRDATA
  );

  modport slave (
    input  HADDR, HWDATA, HWRITE, HSEL, HTRANS,
    output HRDATA
  );
endinterface

// File: rtl/mfp_ahb_multibot_io.sv
// ---------------------------------------------------------------------------
// mfp_ahb_multibot_io
//   AHB-Lite register block serving NUM_BOTS Rojobot channels. Each channel
//   snapshots its bot info when its (asynchronous) update strobe rises, flags
//   the event as pending, counts overruns, and exposes an 8-bit control
//   register. A global enable mask turns pending flags into an interrupt.
//
//   Register map (channel base B = 0x20*n):
//     B+0x00 INFO    RO  info snapshot
//     B+0x04 CTRL    RW  [7:0]
//     B+0x08 STATUS  RO  [0] pending, [15:8] overrun count
//     B+0x0C ACK     WO  [0] clears pending, [1] clears overrun count
//     0x80   IRQ_EN  RW  [NUM_BOTS-1:0]
//     0x84   IRQ_PEND RO [NUM_BOTS-1:0]
//
//   Ports:
//     HCLK, HRESETn  clock, asynchronous active-low reset
//     ahb            AHB slave bundle (mfp_ahb_multibot_io_if.slave)
//     H_BOT_INFO     bot info, channel n at [32n+31:32n]
//     H_BOT_UPDATE   per-bot update strobes, asynchronous to HCLK
//     H_BOT_CTRL     bot control, channel n at [8n+7:8n]
//     H_IRQ          registered interrupt request
// ---------------------------------------------------------------------------
module mfp_ahb_multibot_io #(
  parameter int NUM_BOTS    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  mfp_ahb_multibot_io_if.slave    ahb,
  input  logic [NUM_BOTS*32-1:0]  H_BOT_INFO,
  input  logic [NUM_BOTS-1:0]     H_BOT_UPDATE,
  output logic [NUM_BOTS*8-1:0]   H_BOT_CTRL,
  output logic                    H_IRQ
);

  // Registered address phase
  logic [7:0] haddr_q;
  logic       hwrite_q;
  logic       hsel_q;
  logic [1:0] htrans_q;
  logic       wr_en;

  // Channel state
  logic [31:0]               info_q [NUM_BOTS];
  logic [7:0]                ctrl_q [NUM_BOTS];
  logic [7:0]                ovr_q  [NUM_BOTS];
  logic [NUM_BOTS-1:0]       pending_q;
  logic [NUM_BOTS-1:0]       irq_en_q;

  // Update synchronizers and edge detect
  logic [SYNC_STAGES-1:0]    sync_q [NUM_BOTS];
  logic [NUM_BOTS-1:0]       sync_last;
  logic [NUM_BOTS-1:0]       edge_q;
  logic [NUM_BOTS-1:0]       upd_edge;

  // Write decode
  logic [NUM_BOTS-1:0]       wr_ctrl;
  logic [NUM_BOTS-1:0]       wr_ack;
  logic [NUM_BOTS-1:0]       ack_pend;
  logic [NUM_BOTS-1:0]       ack_ovr;
  logic                      wr_irq_en;

  // Read path
  logic                      rd_en;
  logic [31:0]               rd_mux;
  logic [31:0]               hrdata_q;

  // Only the low control/ack/enable bits of HWDATA are architected.
  logic                      unused_hwdata;
  assign unused_hwdata = ^ahb.HWDATA[31:8];

  // -------------------------------------------------------------------------
  // Address phase register. Captured every cycle; a reset mid-transfer
  // clears it, which is what aborts an in-flight write.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsel_q   <= 1'b0;
      htrans_q <= '0;
    end else begin
      haddr_q  <= ahb.HADDR;
      hwrite_q <= ahb.HWRITE;
      hsel_q   <= ahb.HSEL;
      htrans_q <= ahb.HTRANS;
    end
  end

  assign wr_en = hsel_q & hwrite_q & (htrans_q != 2'b00);

  // Channels n>=NUM_BOTS and unmapped offsets never match, so writes to
  // them fall through with no effect.
  always_comb begin
    wr_ctrl   = '0;
    wr_ack    = '0;
    wr_irq_en = 1'b0;
    if (wr_en) begin
      if (haddr_q == 8'h80) wr_irq_en = 1'b1;
      for (int n = 0; n < NUM_BOTS; n++) begin
        if (haddr_q[7:5] == 3'(n)) begin
          if (haddr_q[4:0] == 5'h04) wr_ctrl[n] = 1'b1;
          if (haddr_q[4:0] == 5'h0C) wr_ack[n]  = 1'b1;
        end
      end
    end
  end

  assign ack_pend = wr_ack & {NUM_BOTS{ahb.HWDATA[0]}};
  assign ack_ovr  = wr_ack & {NUM_BOTS{ahb.HWDATA[1]}};

  // -------------------------------------------------------------------------
  // Update synchronizer: SYNC_STAGES flops, then one flop for edge detect.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int n = 0; n < NUM_BOTS; n++) sync_q[n] <= '0;
      edge_q <= '0;
    end else begin
      for (int n = 0; n < NUM_BOTS; n++)
        sync_q[n] <= {sync_q[n][SYNC_STAGES-2:0], H_BOT_UPDATE[n]};
      edge_q <= sync_last;
    end
  end

  always_comb begin
    sync_last = '0;
    for (int n = 0; n < NUM_BOTS; n++) sync_last[n] = sync_q[n][SYNC_STAGES-1];
  end

  assign upd_edge = sync_last & ~edge_q;

  // -------------------------------------------------------------------------
  // Channel registers. Priorities: a detected edge beats an ACK pending
  // clear; an ACK overrun clear beats an increment. An edge coincident with
  // an ACK pending clear is treated as a fresh event, not an overrun.
  // -------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int n = 0; n < NUM_BOTS; n++) begin
        info_q[n] <= '0;
        ctrl_q[n] <= '0;
        ovr_q[n]  <= '0;
      end
      pending_q <= '0;
      irq_en_q  <= '0;
    end else begin
      for (int n = 0; n < NUM_BOTS; n++) begin
        if (upd_edge[n]) info_q[n] <= H_BOT_INFO[32*n +: 32];
        if (wr_ctrl[n])  ctrl_q[n] <= ahb.HWDATA[7:0];

        if (upd_edge[n])      pending_q[n] <= 1'b1;
        else if (ack_pend[n]) pending_q[n] <= 1'b0;

        if (ack_ovr[n])
          ovr_q[n] <= '0;
        else if (upd_edge[n] && pending_q[n] && !ack_pend[n] && (ovr_q[n] != 8'hFF))
          ovr_q[n] <= ovr_q[n] + 8'd1;
      end
      if (wr_irq_en) irq_en_q <= ahb.HWDATA[NUM_BOTS-1:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) H_IRQ <= 1'b0;
    else          H_IRQ <= |(pending_q & irq_en_q);
  end

  for (genvar g = 0; g < NUM_BOTS; g++) begin : g_ctrl_out
    assign H_BOT_CTRL[8*g +: 8] = ctrl_q[g];
  end

  // -------------------------------------------------------------------------
  // Read path: decoded from the live address phase and registered, so data
  // appears in the data-phase cycle with no wait state.
  // -------------------------------------------------------------------------
  assign rd_en = ahb.HSEL & ~ahb.HWRITE & (ahb.HTRANS != 2'b00);

  always_comb begin
    rd_mux = '0;
    if (ahb.HADDR == 8'h80) rd_mux[NUM_BOTS-1:0] = irq_en_q;
    if (ahb.HADDR == 8'h84) rd_mux[NUM_BOTS-1:0] = pending_q;
    for (int n = 0; n < NUM_BOTS; n++) begin
      if (ahb.HADDR[7:5] == 3'(n)) begin
        case (ahb.HADDR[4:0])
          5'h00:   rd_mux = info_q[n];
          5'h04:   rd_mux[7:0] = ctrl_q[n];
          5'h08: begin
            rd_mux[0]    = pending_q[n];
            rd_mux[15:8] = ovr_q[n];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)   hrdata_q <= '0;
    else if (rd_en) hrdata_q <= rd_mux;
  end

  assign ahb.HRDATA = hrdata_q;

endmodule

// File: tb/tb_mfp_ahb_multibot_io.sv
// ---------------------------------------------------------------------------
// tb_mfp_ahb_multibot_io
//   Directed bench for mfp_ahb_multibot_io with NUM_BOTS=2, SYNC_STAGES=2.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge, half a period away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_mfp_ahb_multibot_io;

  logic        HCLK;
  logic        HRESETn;
  logic [63:0] bot_info;
  logic [1:0]  bot_update;
  logic [15:0] bot_ctrl;
  logic        irq;

  int checks;
  int errors;

  mfp_ahb_multibot_io_if ahb_if ();

  mfp_ahb_multibot_io #(
    .NUM_BOTS    (2),
    .SYNC_STAGES (2)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .ahb          (ahb_if),
    .H_BOT_INFO   (bot_info),
    .H_BOT_UPDATE (bot_update),
    .H_BOT_CTRL   (bot_ctrl),
    .H_IRQ        (irq)
  );

  // Clock / reset
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------------------------------------------------------- drivers
  // Entered on a falling edge; returns on the falling edge right after the
  // data-phase rising edge, with the bus idle.
  task automatic ahb_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [1:0] trans = 2'b10);
    ahb_if.HADDR  = addr;
    ahb_if.HWRITE = 1'b1;
    ahb_if.HSEL   = 1'b1;
    ahb_if.HTRANS = trans;
    @(negedge HCLK);
    ahb_if.HWDATA = data;
    ahb_if.HWRITE = 1'b0;
    ahb_if.HSEL   = 1'b0;
    ahb_if.HTRANS = 2'b00;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [7:0] addr, output logic [31:0] data);
    ahb_if.HADDR  = addr;
    ahb_if.HWRITE = 1'b0;
    ahb_if.HSEL   = 1'b1;
    ahb_if.HTRANS = 2'b10;
    @(negedge HCLK);
    data = ahb_if.HRDATA;
    ahb_if.HSEL   = 1'b0;
    ahb_if.HTRANS = 2'b00;
  endtask

  // Two cycles high, two low: each pulse is one detected edge.
  task automatic pulse(input logic [1:0] mask);
    bot_update = mask;
    repeat (2) @(negedge HCLK);
    bot_update = 2'b00;
    repeat (2) @(negedge HCLK);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] rd;
    checks++; if (ahb_if.HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata: got %h expected %h", ahb_if.HRDATA, 32'h0); end
    checks++; if (bot_ctrl !== 16'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected %h", bot_ctrl, 16'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    HRESETn = 1'b1;
    @(negedge HCLK);
    ahb_read(8'h00, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_info0: got %h expected %h", rd, 32'h0); end
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status0: got %h expected %h", rd, 32'h0); end
    ahb_read(8'h80, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_irq_en: got %h expected %h", rd, 32'h0); end
  endtask

  task automatic test_ctrl();
    logic [31:0] rd;
    ahb_write(8'h04, 32'h0000_00A5);
    ahb_write(8'h24, 32'hFFFF_FF3C);
    checks++; if (bot_ctrl !== 16'h3CA5) begin errors++; $display("FAIL ctrl_out: got %h expected %h", bot_ctrl, 16'h3CA5); end
    ahb_read(8'h04, rd);
    checks++; if (rd !== 32'h0000_00A5) begin errors++; $display("FAIL ctrl0_read: got %h expected %h", rd, 32'h0000_00A5); end
    ahb_read(8'h24, rd);
    checks++; if (rd !== 32'h0000_003C) begin errors++; $display("FAIL ctrl1_read: got %h expected %h", rd, 32'h0000_003C); end
  endtask

  task automatic test_update_latency();
    logic [31:0] rd;
    ahb_write(8'h80, 32'h1);
    ahb_read(8'h80, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL irq_en_read: got %h expected %h", rd, 32'h1); end
    bot_info[31:0] = 32'h1234_5678;
    bot_update[0] = 1'b1;
    repeat (2) @(negedge HCLK);
    bot_update[0] = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lat_irq_e2: got %b expected 0", irq); end
    @(negedge HCLK);  // 3rd edge: pending set, IRQ not yet
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL lat_irq_e3: got %b expected 0", irq); end
    @(negedge HCLK);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL lat_irq_e4: got %b expected 1", irq); end
    bot_info[31:0] = 32'hDEAD_BEEF;  // no update: snapshot must hold
    ahb_read(8'h00, rd);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL lat_info0: got %h expected %h", rd, 32'h1234_5678); end
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL lat_status0: got %h expected %h", rd, 32'h1); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd;
    ahb_write(8'h0C, 32'h1);
    @(negedge HCLK);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_cleared: got %b expected 0", irq); end
    pulse(2'b01);
    pulse(2'b01);
    bot_info[31:0] = 32'h0BAD_CAFE;
    pulse(2'b01);
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0000_0201) begin errors++; $display("FAIL ovr_status: got %h expected %h", rd, 32'h0000_0201); end
    ahb_read(8'h00, rd);
    checks++; if (rd !== 32'h0BAD_CAFE) begin errors++; $display("FAIL ovr_info_refresh: got %h expected %h", rd, 32'h0BAD_CAFE); end
    ahb_write(8'h0C, 32'h3);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq_lag: got %b expected 1", irq); end
    @(negedge HCLK);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ovr_irq_clear: got %b expected 0", irq); end
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ovr_status_clear: got %h expected %h", rd, 32'h0); end
  endtask

  task automatic test_saturate_and_races();
    logic [31:0] rd;
    for (int i = 0; i < 300; i++) pulse(2'b01);
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0000_FF01) begin errors++; $display("FAIL sat_status: got %h expected %h", rd, 32'h0000_FF01); end
    ahb_write(8'h0C, 32'h2);
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL sat_ovr_clear: got %h expected %h", rd, 32'h1); end

    // ACK bit0 write lands on the same rising edge as the detected edge.
    bot_update[0] = 1'b1;
    @(negedge HCLK);
    ahb_write(8'h0C, 32'h1);
    bot_update[0] = 1'b0;
    repeat (3) @(negedge HCLK);
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL race_ack0: got %h expected %h", rd, 32'h1); end

    pulse(2'b01);
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0000_0101) begin errors++; $display("FAIL race_pre: got %h expected %h", rd, 32'h0000_0101); end

    // ACK bit1 write lands on the same edge as an overrun increment.
    bot_update[0] = 1'b1;
    @(negedge HCLK);
    ahb_write(8'h0C, 32'h2);
    bot_update[0] = 1'b0;
    repeat (3) @(negedge HCLK);
    ahb_read(8'h08, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL race_ack1: got %h expected %h", rd, 32'h1); end
  endtask

  task automatic test_two_channels();
    logic [31:0] rd;
    ahb_write(8'h0C, 32'h3);
    ahb_write(8'h80, 32'h3);
    bot_info = {32'h2222_2222, 32'h1111_1111};
    pulse(2'b11);
    ahb_read(8'h00, rd);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL dual_info0: got %h expected %h", rd, 32'h1111_1111); end
    ahb_read(8'h20, rd);
    checks++; if (rd !== 32'h2222_2222) begin errors++; $display("FAIL dual_info1: got %h expected %h", rd, 32'h2222_2222); end
    ahb_read(8'h28, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL dual_status1: got %h expected %h", rd, 32'h1); end
    ahb_read(8'h84, rd);
    checks++; if (rd !== 32'h0000_0003) begin errors++; $display("FAIL dual_pend: got %h expected %h", rd, 32'h3); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL dual_irq: got %b expected 1", irq); end
    ahb_write(8'h0C, 32'h1);
    ahb_read(8'h84, rd);
    checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL dual_pend_ch1: got %h expected %h", rd, 32'h2); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL dual_irq_ch1: got %b expected 1", irq); end
    ahb_write(8'h80, 32'h1);
    @(negedge HCLK);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL dual_irq_masked: got %b expected 0", irq); end
    ahb_write(8'h2C, 32'h1);
    ahb_read(8'h84, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL dual_pend_clear: got %h expected %h", rd, 32'h0); end
  endtask

  task automatic test_ignored();
    logic [31:0] rd;
    ahb_write(8'h60, 32'hFFFF_FFFF);
    ahb_write(8'h64, 32'hFFFF_FFFF);
    ahb_write(8'h88, 32'hFFFF_FFFF);
    ahb_write(8'h84, 32'hFFFF_FFFF);
    ahb_write(8'h00, 32'h0);
    ahb_write(8'h04, 32'h11, 2'b00);  // IDLE with HSEL=1, HWRITE=1
    checks++; if (bot_ctrl !== 16'h3CA5) begin errors++; $display("FAIL ign_ctrl: got %h expected %h", bot_ctrl, 16'h3CA5); end
    ahb_read(8'h60, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_rd60: got %h expected %h", rd, 32'h0); end
    ahb_read(8'h64, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_rd64: got %h expected %h", rd, 32'h0); end
    ahb_read(8'h88, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_rd88: got %h expected %h", rd, 32'h0); end
    ahb_read(8'h0C, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_rd_ack: got %h expected %h", rd, 32'h0); end
    ahb_read(8'h84, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL ign_rd_pend: got %h expected %h", rd, 32'h0); end
    ahb_read(8'h00, rd);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL ign_info_ro: got %h expected %h", rd, 32'h1111_1111); end
    ahb_read(8'h80, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL ign_irq_en: got %h expected %h", rd, 32'h1); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    pulse(2'b01);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL abort_pre_irq: got %b expected 1", irq); end
    ahb_read(8'h00, rd);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL abort_pre_rd: got %h expected %h", rd, 32'h1111_1111); end
    bot_info[63:32] = 32'hCAFE_F00D;
    bot_update[1] = 1'b1;
    // CTRL write: address phase, then reset in the data phase.
    ahb_if.HADDR  = 8'h04;
    ahb_if.HWRITE = 1'b1;
    ahb_if.HSEL   = 1'b1;
    ahb_if.HTRANS = 2'b10;
    @(negedge HCLK);
    ahb_if.HWDATA = 32'h77;
    ahb_if.HWRITE = 1'b0;
    ahb_if.HSEL   = 1'b0;
    ahb_if.HTRANS = 2'b00;
    HRESETn = 1'b0;
    #1;
    checks++; if (ahb_if.HRDATA !== 32'h0) begin errors++; $display("FAIL abort_hrdata: got %h expected %h", ahb_if.HRDATA, 32'h0); end
    checks++; if (bot_ctrl !== 16'h0) begin errors++; $display("FAIL abort_ctrl: got %h expected %h", bot_ctrl, 16'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL abort_irq: got %b expected 0", irq); end
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);
    checks++; if (bot_ctrl !== 16'h0) begin errors++; $display("FAIL abort_ctrl_after: got %h expected %h", bot_ctrl, 16'h0); end
    bot_update[1] = 1'b0;
    repeat (2) @(negedge HCLK);
    ahb_read(8'h28, rd);
    checks++; if (rd !== 32'h0000_0001) begin errors++; $display("FAIL rel_status1: got %h expected %h", rd, 32'h1); end
    ahb_read(8'h20, rd);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL rel_info1: got %h expected %h", rd, 32'hCAFE_F00D); end
    ahb_read(8'h04, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_ctrl_rd: got %h expected %h", rd, 32'h0); end
  endtask

  // ------------------------------------------------------------------- main
  initial begin
    checks        = 0;
    errors        = 0;
    HRESETn       = 1'b0;
    bot_info      = '0;
    bot_update    = '0;
    ahb_if.HADDR  = '0;
    ahb_if.HWDATA = '0;
    ahb_if.HWRITE = 1'b0;
    ahb_if.HSEL   = 1'b0;
    ahb_if.HTRANS = 2'b00;
    repeat (3) @(negedge HCLK);

    test_reset();
    test_ctrl();
    test_update_latency();
    test_overrun();
    test_saturate_and_races();
    test_two_channels();
    test_ignored();
    test_reset_abort();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
